// File: rtl/rsa_encrypt_if.sv
// Request/result bundle for the RSA public-key exponentiator.
// The master drives the request; the slave returns C and status.
interface rsa_encrypt_if #(
    parameter int MW = 16,
    parameter int EW = 8
);
    logic          start;
    logic [MW-1:0] M;
    logic [EW-1:0] e;
    logic [MW-1:0] n;
    logic [MW-1:0] C;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, M, e, n,
        input  C, busy, done, err
    );

    modport slave (
        input  start, M, e, n,
        output C, busy, done, err
    );
endinterface

// File: rtl/rsa_encrypt.sv
// RSA public-key exponentiator: C = M^e mod n.
// Left-to-right square-and-multiply over a bit-serial modular multiplier.
module rsa_encrypt #(
    parameter int MW = 16,
    parameter int EW = 8
) (
    input  logic        clk,
    input  logic        rst,
    rsa_encrypt_if.slave bus
);
    localparam int JW = $clog2(MW);
    localparam int IW = $clog2(EW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SQUARE,
        S_MULT,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [MW-1:0] r_m;
    logic [EW-1:0] r_e;
    logic [MW-1:0] r_n;
    logic [MW-1:0] r_r;
    logic [MW-1:0] r_base;
    logic [MW-1:0] r_c;
    logic [MW+1:0] r_p;
    logic [JW-1:0] r_j;
    logic [IW-1:0] r_i;
    logic          r_err;

    logic [MW-1:0] w_a;
    logic [MW-1:0] w_b;
    logic [MW+1:0] w_n_ext;
    logic [MW+1:0] w_sum;
    logic [MW+1:0] w_s1;
    logic [MW+1:0] w_s2;
    logic [MW-1:0] w_res;
    logic          w_last;
    logic          w_ebit;
    logic          w_accept;
    logic          w_n_one;

    // Multiplier operands: REDUCE folds M into range, MULT uses the base.
    always_comb begin
        w_a = r_r;
        w_b = r_r;
        unique case (r_state)
            S_REDUCE: begin
                w_a = r_m;
                w_b = MW'(1);
            end
            S_MULT:  w_b = r_base;
            default: ;
        endcase
    end

    // One interleaved step: P = 2P + a[j]*b, then at most two subtractions keep P < n.
    always_comb begin
        w_n_ext = {2'b00, r_n};
        w_sum   = (r_p << 1) + (w_a[r_j] ? {2'b00, w_b} : '0);
        w_s1    = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        w_s2    = (w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1;
        w_n_one = (r_n == MW'(1));
        w_res   = w_n_one ? '0 : w_s2[MW-1:0];
        w_last  = (r_j == '0);
        w_ebit  = r_e[r_i];
        w_accept = (r_state == S_IDLE) && bus.start;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: every exponent bit is scanned, leading zeros included.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.n == '0) ? S_FIN : S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (w_last) w_state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
                if (w_last) begin
                    if (w_ebit)             w_state_nxt = S_MULT;
                    else if (r_i == '0)     w_state_nxt = S_FIN;
                    else                    w_state_nxt = S_SQUARE;
                end
            end
            S_MULT: begin
                if (w_last) begin
                    w_state_nxt = (r_i == '0) ? S_FIN : S_SQUARE;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, run the multiplier, retire each product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m    <= '0;
            r_e    <= '0;
            r_n    <= '0;
            r_r    <= '0;
            r_base <= '0;
            r_c    <= '0;
            r_p    <= '0;
            r_j    <= '0;
            r_i    <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_m    <= bus.M;
            r_e    <= bus.e;
            r_n    <= bus.n;
            r_c    <= '0;
            r_err  <= (bus.n == '0);
            r_r    <= (bus.n == MW'(1)) ? '0 : MW'(1);
            r_base <= '0;
            r_p    <= '0;
            r_j    <= JW'(MW - 1);
            r_i    <= IW'(EW - 1);
        end else if (r_state inside {S_REDUCE, S_SQUARE, S_MULT}) begin
            r_j <= r_j - JW'(1);
            r_p <= w_last ? '0 : w_s2;
            if (w_last) begin
                if (r_state == S_REDUCE) r_base <= w_res;
                else                     r_r    <= w_res;
                if (w_state_nxt == S_FIN) r_c <= w_res;
                if (r_state == S_MULT || (r_state == S_SQUARE && !w_ebit)) begin
                    r_i <= r_i - IW'(1);
                end
            end
        end
    end

    assign bus.C    = r_c;
    assign bus.err  = r_err;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_FIN);
endmodule
